sysbus_uart_tx: RTL and testbench

- Memory-mapped serial transmitter that responds to CPU bus cycles on the shared tri-state sysbus.
- The sequencer is the bus initiator; this block is a bus responder, like RAM/ROM/SSR.
- It captures the address when MAR is loaded, accepts byte writes into a small FIFO, and returns status on reads.
- It shifts queued bytes out on `txd` as asynchronous serial frames: 8N1, LSB first.

---
 rtl/sysbus_uart_tx_pkg.sv | 28 ++
 rtl/sysbus_uart_tx_if.sv | 20 ++
 rtl/sysbus_uart_tx_fifo.sv | 61 ++++++
 rtl/sysbus_uart_tx.sv | 159 +++++++++++++++
 tb/tb_sysbus_uart_tx.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sysbus_uart_tx_pkg.sv
// Shared types and constants for the sysbus UART transmitter.
// Build option: UART_TX_PARITY_EN adds an even-parity bit.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_SHIFT = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_PAR   = 4;

  localparam int OFF_DATA = 0;
  localparam int OFF_STAT = 1;

`ifdef UART_TX_PARITY_EN
  localparam int CNT_LSB = 5;
`else
  localparam int CNT_LSB = 4;
`endif

endpackage

// File: rtl/sysbus_uart_tx_if.sv
// Shared tri-state system bus plus the sequencer strobes.
// The initiator drives the strobes; responders only watch them.
interface sysbus_uart_tx_if #(
  parameter int WORD_W = 8
);
  wire [WORD_W-1:0] sysbus;
  logic load_MAR;
  logic CS;
  logic R_NW;

  modport master (
    inout  sysbus,
    output load_MAR, CS, R_NW
  );

  modport slave (
    inout sysbus,
    input load_MAR, CS, R_NW
  );
endinterface

// File: rtl/sysbus_uart_tx_fifo.sv
// Transmit FIFO with head-of-queue combinational output.
// A push while full is taken only when a pop frees a slot.
module tx_fifo #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WORD_W-1:0]      din,
  output logic [WORD_W-1:0]      dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rptr_q];

  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/sysbus_uart_tx.sv
// Memory-mapped 8N1 serial transmitter responding on the sysbus.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit.
module sysbus_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int                    WORD_W       = 8,
  parameter int                    OP_W         = 3,
  parameter logic [WORD_W-OP_W-1:0] BASE_ADDR   = 5'd30,
  parameter int                    CLKS_PER_BIT = 4,
  parameter int                    FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  sysbus_uart_tx_if.slave       bus,
  output logic                  txd,
  output logic                  busy
);
  localparam int AW = WORD_W - OP_W;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(WORD_W);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t         state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              ovf_q, ovf_d;
  logic [AW-1:0]     addr_q, addr_d;

  logic              hit_data, hit_stat;
  logic              wr_data, rd_stat;
  logic              pop, baud_end;
  logic              f_full, f_empty;
  logic [WORD_W-1:0] f_dout;
  logic [CW-1:0]     f_cnt;
  logic [WORD_W-1:0] stat;

  tx_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (wr_data),
    .pop   (pop),
    .din   (bus.sysbus),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_cnt)
  );

  assign hit_data = (addr_q == BASE_ADDR + AW'(OFF_DATA));
  assign hit_stat = (addr_q == BASE_ADDR + AW'(OFF_STAT));
  assign wr_data  = bus.CS && !bus.R_NW && hit_data;
  assign rd_stat  = bus.CS && bus.R_NW && hit_stat;
  assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    stat           = '0;
    stat[ST_FULL]  = f_full;
    stat[ST_EMPTY] = f_empty;
    stat[ST_SHIFT] = (state_q != IDLE);
    stat[ST_OVF]   = ovf_q;
`ifdef UART_TX_PARITY_EN
    stat[ST_PAR]   = 1'b1;
`endif
    stat[WORD_W-1:CNT_LSB] = (WORD_W-CNT_LSB)'(f_cnt);
  end

  assign bus.sysbus = rd_stat ? stat : 'z;
  assign txd  = txd_q;
  assign busy = (state_q != IDLE) || !f_empty;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    baud_d  = baud_end ? '0 : baud_q + BW'(1);
    addr_d  = bus.load_MAR ? bus.sysbus[AW-1:0] : addr_q;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!f_empty) begin
          pop     = 1'b1;
          shift_d = f_dout;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (baud_end) begin
          if (idx_q == IW'(WORD_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PARITY: begin
        if (baud_end) state_d = STOP;
      end
      STOP: begin
        if (baud_end) begin
          if (!f_empty) begin
            pop     = 1'b1;
            shift_d = f_dout;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level tracks the current state, so it lags the pop by one edge.
    unique case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[idx_q];
      PARITY:  txd_d = ^shift_q;
      default: txd_d = 1'b1;
    endcase
    ovf_d = ovf_q;
    if (wr_data && f_full && !pop) ovf_d = 1'b1;
    else if (rd_stat)              ovf_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_sysbus_uart_tx.sv
// Directed bench for sysbus_uart_tx, default and parity builds.
module tb_sysbus_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FC = FB * 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       txd, busy;
  logic       drv_en = 1'b0;
  logic [7:0] drv_val = 8'h00;
  int         n_cmp = 0;
  int         n_err = 0;

  sysbus_uart_tx_if #(.WORD_W(8)) bus ();
  assign bus.sysbus = drv_en ? drv_val : 8'bz;

  sysbus_uart_tx #(
    .WORD_W       (8),
    .OP_W         (3),
    .BASE_ADDR    (5'd30),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .txd   (txd),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] st_exp(int cnt, bit ovf, bit sh,
                                        bit full, bit empty);
`ifdef UART_TX_PARITY_EN
    return {cnt[2:0], 1'b1, ovf, sh, empty, full};
`else
    return {cnt[3:0], ovf, sh, empty, full};
`endif
  endfunction

  function automatic logic [10:0] frm(logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_addr(input logic [4:0] a);
    drv_val = {3'b000, a};
    drv_en = 1'b1;
    bus.load_MAR = 1'b1;
    cyc();
    bus.load_MAR = 1'b0;
    drv_en = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d);
    drv_val = d;
    drv_en = 1'b1;
    bus.CS = 1'b1;
    bus.R_NW = 1'b0;
    cyc();
    bus.CS = 1'b0;
    drv_en = 1'b0;
  endtask

  task automatic read_bus(output logic [7:0] v);
    drv_en = 1'b0;
    bus.CS = 1'b1;
    bus.R_NW = 1'b1;
    #1 v = bus.sysbus;
    cyc();
    bus.CS = 1'b0;
  endtask

  task automatic capture(input int n, output logic [131:0] s);
    s = '0;
    for (int k = 0; k < n; k++) begin
      s[k] = txd;
      cyc();
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if (txd !== 1'b1) begin
      n_err++; $display("FAIL reset_txd: got %b expected 1", txd);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    reset = 1'b0;
    set_addr(5'd31);
    read_bus(v);
    n_cmp++;
    if (v !== st_exp(0, 0, 0, 0, 1)) begin
      n_err++;
      $display("FAIL reset_status: got %h expected %h", v, st_exp(0, 0, 0, 0, 1));
    end
  endtask

  task automatic test_single();
    logic [131:0] s, e;
    logic [10:0]  f;
    set_addr(5'd30);
    write_byte(8'hA5);
    cyc();
    n_cmp++;
    if (txd !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_pop_edge: got txd=%b busy=%b expected txd=1 busy=1", txd, busy);
    end
    cyc();
    capture(FC, s);
    f = frm(8'hA5);
    e = '0;
    for (int i = 0; i < FC; i++) e[i] = f[i/4];
    n_cmp++;
    if (s !== e) begin
      n_err++; $display("FAIL single_frame: got %h expected %h", s, e);
    end
    n_cmp++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      n_err++;
      $display("FAIL single_idle: got busy=%b txd=%b expected busy=0 txd=1", busy, txd);
    end
  endtask

  task automatic test_back_to_back();
    logic [131:0] s, e;
    logic [10:0]  f [3];
    logic [7:0]   v;
    f[0] = frm(8'h01);
    f[1] = frm(8'h80);
    f[2] = frm(8'hFF);
    e = '0;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < FC; i++) e[j*FC + i] = f[j][i/4];
    write_byte(8'h01);
    write_byte(8'h80);
    write_byte(8'hFF);
    fork
      capture(3 * FC, s);
      begin
        set_addr(5'd31);
        repeat (19) cyc();
        for (int c = 2; c >= 0; c--) begin
          read_bus(v);
          n_cmp++;
          if (v !== st_exp(c, 0, 1, 0, c == 0)) begin
            n_err++;
            $display("FAIL b2b_status_cnt%0d: got %h expected %h", c, v, st_exp(c, 0, 1, 0, c == 0));
          end
          if (c > 0) repeat (39) cyc();
        end
      end
    join
    n_cmp++;
    if (s !== e) begin
      n_err++; $display("FAIL b2b_frames: got %h expected %h", s, e);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    int t;
    set_addr(5'd30);
    for (int i = 0; i < 6; i++) write_byte(8'h11 + 8'(i));
    set_addr(5'd31);
    read_bus(v);
    n_cmp++;
    if (v !== st_exp(4, 1, 1, 1, 0)) begin
      n_err++; $display("FAIL ovf_status: got %h expected %h", v, st_exp(4, 1, 1, 1, 0));
    end
    read_bus(v);
    n_cmp++;
    if (v !== st_exp(4, 0, 1, 1, 0)) begin
      n_err++; $display("FAIL ovf_clear: got %h expected %h", v, st_exp(4, 0, 1, 1, 0));
    end
    t = 0;
    while (busy && t < 400) begin
      cyc();
      t++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL ovf_drain: got busy=%b after %0d cycles expected 0", busy, t);
    end
  endtask

  task automatic test_isolation();
    logic [7:0] v;
    logic [4:0] a [2];
    a[0] = 5'd30;
    a[1] = 5'd5;
    for (int i = 0; i < 2; i++) begin
      set_addr(a[i]);
      drv_val = 8'h00;
      drv_en = 1'b1;
      bus.CS = 1'b1;
      bus.R_NW = 1'b1;
      #1 v = bus.sysbus;
      n_cmp++;
      if (v !== 8'h00) begin
        n_err++; $display("FAIL iso_read_a%0d: got %h expected 00", a[i], v);
      end
      cyc();
      bus.CS = 1'b0;
      drv_en = 1'b0;
    end
    set_addr(5'd7);
    write_byte(8'h55);
    cyc();
    n_cmp++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      n_err++;
      $display("FAIL iso_write: got busy=%b txd=%b expected busy=0 txd=1", busy, txd);
    end
    set_addr(5'd31);
    read_bus(v);
    n_cmp++;
    if (v !== st_exp(0, 0, 0, 0, 1)) begin
      n_err++; $display("FAIL iso_status: got %h expected %h", v, st_exp(0, 0, 0, 0, 1));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    int lows;
    set_addr(5'd30);
    write_byte(8'h3C);
    write_byte(8'hAA);
    write_byte(8'h55);
    repeat (15) cyc();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL mid_busy_before: got %b expected 1", busy);
    end
    reset = 1'b1;
    cyc();
    n_cmp++;
    if (txd !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got txd=%b busy=%b expected txd=1 busy=0", txd, busy);
    end
    reset = 1'b0;
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      if (txd !== 1'b1) lows++;
      cyc();
    end
    n_cmp++;
    if (lows != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_quiet: got %0d low cycles busy=%b expected 0 and 0", lows, busy);
    end
    set_addr(5'd31);
    read_bus(v);
    n_cmp++;
    if (v !== st_exp(0, 0, 0, 0, 1)) begin
      n_err++; $display("FAIL mid_status: got %h expected %h", v, st_exp(0, 0, 0, 0, 1));
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [131:0] s, e;
    logic [10:0]  f;
    logic [7:0]   v;
    set_addr(5'd30);
    write_byte(8'h07);
    cyc();
    cyc();
    capture(44, s);
    f = 11'b1_1_00000111_0;
    e = '0;
    for (int i = 0; i < 44; i++) e[i] = f[i/4];
    n_cmp++;
    if (s !== e) begin
      n_err++; $display("FAIL parity_frame: got %h expected %h", s, e);
    end
    set_addr(5'd31);
    read_bus(v);
    n_cmp++;
    if (v[4] !== 1'b1) begin
      n_err++; $display("FAIL parity_flag: got %b expected 1", v[4]);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.load_MAR = 1'b0;
    bus.CS = 1'b0;
    bus.R_NW = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_isolation();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
